// File: rtl/pic_buf_loader_if.sv
// Bundle between pic_buf_loader and its picture memory, buffer and window consumer.
// Carries stall_cnt only when PIC_LOADER_STALL_CNT_EN is defined.
interface pic_buf_loader_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              start;
   logic [ADDR_W-1:0] img_base;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_valid;
   logic [31:0]       mem_data;
   logic              buf_we;
   logic              buf_shift;
   logic              buf_re;
   logic [1:0]        buf_i;
   logic [3:0]        buf_j;
   logic [31:0]       buf_din;
   logic              win_valid;
   logic              win_ready;
   logic              win_last;
   logic              busy;
   logic              done;
`ifdef PIC_LOADER_STALL_CNT_EN
   logic [15:0]       stall_cnt;
`endif

   modport master (
      input  start, img_base, mem_valid, mem_data, win_ready,
      output mem_rd, mem_addr, buf_we, buf_shift, buf_re, buf_i, buf_j, buf_din,
      output win_valid, win_last, busy, done
`ifdef PIC_LOADER_STALL_CNT_EN
      , output stall_cnt
`endif
   );

   modport slave (
      output start, img_base, mem_valid, mem_data, win_ready,
      input  mem_rd, mem_addr, buf_we, buf_shift, buf_re, buf_i, buf_j, buf_din,
      input  win_valid, win_last, busy, done
`ifdef PIC_LOADER_STALL_CNT_EN
      , input stall_cnt
`endif
   );
endinterface

// File: rtl/pic_buf_loader.sv
// Fills the 4x16-byte picture buffer from picture memory and steps it through every 4x4 window.
// Optional window-stall counter enabled by defining PIC_LOADER_STALL_CNT_EN.
module pic_buf_loader #(
   parameter int unsigned IMG_ROWS = 16,
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned STRIDE   = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   pic_buf_loader_if.master      io_bus
);
   localparam int unsigned RowW = $clog2(IMG_ROWS + 1);

   typedef enum logic [2:0] {StIdle, StRd, StWait, StWr, StWin, StShift, StFin} state_e;

   state_e            r_state;
   logic [RowW-1:0]   r_row;
   logic [1:0]        r_word;
   logic [3:0]        r_col;
   logic [ADDR_W-1:0] r_addr;
   logic              r_mem_rd;
   logic [ADDR_W-1:0] r_mem_addr;
   logic              r_buf_we;
   logic              r_buf_shift;
   logic              r_buf_re;
   logic [1:0]        r_buf_i;
   logic [3:0]        r_buf_j;
   logic [31:0]       r_buf_din;
   logic              r_win_valid;
   logic              r_win_last;
   logic              r_busy;
   logic              r_done;

   logic [RowW-1:0]   w_row_nxt;
   logic [1:0]        w_buf_i;
   logic [4:0]        w_col_step;
   logic              w_col_end;
   logic              w_next_end;
   logic              w_row_full;

   assign w_row_nxt  = r_row + RowW'(1);
   assign w_buf_i    = (r_row > RowW'(3)) ? 2'd3 : r_row[1:0];
   assign w_col_step = {1'b0, r_col} + 5'(STRIDE);
   assign w_col_end  = w_col_step > 5'd15;
   assign w_next_end = (w_col_step + 5'(STRIDE)) > 5'd15;
   assign w_row_full = r_row == RowW'(IMG_ROWS);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= StIdle;
         r_row       <= '0;
         r_word      <= '0;
         r_col       <= '0;
         r_addr      <= '0;
         r_mem_rd    <= 1'b0;
         r_mem_addr  <= '0;
         r_buf_we    <= 1'b0;
         r_buf_shift <= 1'b0;
         r_buf_re    <= 1'b0;
         r_buf_i     <= '0;
         r_buf_j     <= '0;
         r_buf_din   <= '0;
         r_win_valid <= 1'b0;
         r_win_last  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_mem_rd    <= 1'b0;
         r_buf_we    <= 1'b0;
         r_buf_shift <= 1'b0;
         r_done      <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (io_bus.start) begin
                  r_mem_addr <= io_bus.img_base;
                  r_addr     <= io_bus.img_base + ADDR_W'(1);
                  r_mem_rd   <= 1'b1;
                  r_row      <= '0;
                  r_word     <= '0;
                  r_col      <= '0;
                  r_busy     <= 1'b1;
                  r_state    <= StRd;
               end
            end
            StRd: r_state <= StWait;
            StWait: begin
               if (io_bus.mem_valid) begin
                  r_buf_din <= io_bus.mem_data;
                  r_buf_we  <= 1'b1;
                  r_buf_i   <= w_buf_i;
                  r_buf_j   <= {r_word, 2'b00};
                  r_state   <= StWr;
               end
            end
            StWr: begin
               // Image words are fetched strictly in order, so the address just counts up.
               if (r_word != 2'd3 || w_row_nxt < RowW'(4)) begin
                  r_word     <= (r_word == 2'd3) ? 2'd0 : r_word + 2'd1;
                  r_row      <= (r_word == 2'd3) ? w_row_nxt : r_row;
                  r_mem_addr <= r_addr;
                  r_addr     <= r_addr + ADDR_W'(1);
                  r_mem_rd   <= 1'b1;
                  r_state    <= StRd;
               end else begin
                  r_word      <= '0;
                  r_row       <= w_row_nxt;
                  r_col       <= 4'd3;
                  r_buf_j     <= 4'd3;
                  r_buf_re    <= 1'b1;
                  r_win_valid <= 1'b1;
                  // STRIDE <= 4, so the first window of a set is never the last one.
                  r_win_last  <= 1'b0;
                  r_state     <= StWin;
               end
            end
            StWin: begin
               if (io_bus.win_ready) begin
                  if (!w_col_end) begin
                     r_col      <= w_col_step[3:0];
                     r_buf_j    <= w_col_step[3:0];
                     r_win_last <= w_next_end && w_row_full;
                  end else begin
                     r_buf_re    <= 1'b0;
                     r_win_valid <= 1'b0;
                     r_win_last  <= 1'b0;
                     if (!w_row_full) begin
                        r_buf_shift <= 1'b1;
                        r_state     <= StShift;
                     end else begin
                        r_done  <= 1'b1;
                        r_state <= StFin;
                     end
                  end
               end
            end
            StShift: begin
               r_mem_addr <= r_addr;
               r_addr     <= r_addr + ADDR_W'(1);
               r_mem_rd   <= 1'b1;
               r_state    <= StRd;
            end
            StFin: begin
               r_busy  <= 1'b0;
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

`ifdef PIC_LOADER_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stall_cnt <= '0;
      end else if (r_state == StIdle && io_bus.start) begin
         r_stall_cnt <= '0;
      end else if (r_win_valid && !io_bus.win_ready && r_stall_cnt != 16'hFFFF) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign io_bus.stall_cnt = r_stall_cnt;
`endif

   assign io_bus.mem_rd    = r_mem_rd;
   assign io_bus.mem_addr  = r_mem_addr;
   assign io_bus.buf_we    = r_buf_we;
   assign io_bus.buf_shift = r_buf_shift;
   assign io_bus.buf_re    = r_buf_re;
   assign io_bus.buf_i     = r_buf_i;
   assign io_bus.buf_j     = r_buf_j;
   assign io_bus.buf_din   = r_buf_din;
   assign io_bus.win_valid = r_win_valid;
   assign io_bus.win_last  = r_win_last;
   assign io_bus.busy      = r_busy;
   assign io_bus.done      = r_done;
endmodule

// File: tb/tb_pic_buf_loader.sv
// Scoreboard bench for pic_buf_loader: three configurations share one stimulus/monitor path.
// Stall-counter checks are compiled in when PIC_LOADER_STALL_CNT_EN is defined.
module tb_pic_buf_loader;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   int          sel;
   bit          lat_rand;
   logic [2:0]  start_v;
   logic [7:0]  img_base;
   logic        mem_valid;
   logic [31:0] mem_data;
   logic        win_ready;
   logic [63:0] exp_q[$];

   pic_buf_loader_if #(.ADDR_W(8)) if_a ();
   pic_buf_loader_if #(.ADDR_W(8)) if_b ();
   pic_buf_loader_if #(.ADDR_W(8)) if_c ();

   pic_buf_loader #(.IMG_ROWS(4), .ADDR_W(8), .STRIDE(1)) u_a (
      .i_clk(clk), .i_rst_n(rst_n), .io_bus(if_a));
   pic_buf_loader #(.IMG_ROWS(6), .ADDR_W(8), .STRIDE(1)) u_b (
      .i_clk(clk), .i_rst_n(rst_n), .io_bus(if_b));
   pic_buf_loader #(.IMG_ROWS(4), .ADDR_W(8), .STRIDE(4)) u_c (
      .i_clk(clk), .i_rst_n(rst_n), .io_bus(if_c));

   assign if_a.start = start_v[0];
   assign if_b.start = start_v[1];
   assign if_c.start = start_v[2];
   assign if_a.img_base = img_base;
   assign if_b.img_base = img_base;
   assign if_c.img_base = img_base;
   assign if_a.mem_valid = mem_valid;
   assign if_b.mem_valid = mem_valid;
   assign if_c.mem_valid = mem_valid;
   assign if_a.mem_data = mem_data;
   assign if_b.mem_data = mem_data;
   assign if_c.mem_data = mem_data;
   assign if_a.win_ready = win_ready;
   assign if_b.win_ready = win_ready;
   assign if_c.win_ready = win_ready;

   logic [53:0] out_a, out_b, out_c, out_m;
   assign out_a = {if_a.mem_rd, if_a.mem_addr, if_a.buf_we, if_a.buf_shift, if_a.buf_re,
                   if_a.buf_i, if_a.buf_j, if_a.buf_din, if_a.win_valid, if_a.win_last,
                   if_a.busy, if_a.done};
   assign out_b = {if_b.mem_rd, if_b.mem_addr, if_b.buf_we, if_b.buf_shift, if_b.buf_re,
                   if_b.buf_i, if_b.buf_j, if_b.buf_din, if_b.win_valid, if_b.win_last,
                   if_b.busy, if_b.done};
   assign out_c = {if_c.mem_rd, if_c.mem_addr, if_c.buf_we, if_c.buf_shift, if_c.buf_re,
                   if_c.buf_i, if_c.buf_j, if_c.buf_din, if_c.win_valid, if_c.win_last,
                   if_c.busy, if_c.done};
   assign out_m = (sel == 0) ? out_a : (sel == 1) ? out_b : out_c;

   logic        m_mem_rd, m_buf_we, m_buf_shift, m_buf_re, m_win_valid, m_win_last, m_busy, m_done;
   logic [7:0]  m_mem_addr;
   logic [1:0]  m_buf_i;
   logic [3:0]  m_buf_j;
   logic [31:0] m_buf_din;
   assign {m_mem_rd, m_mem_addr, m_buf_we, m_buf_shift, m_buf_re, m_buf_i, m_buf_j, m_buf_din,
           m_win_valid, m_win_last, m_busy, m_done} = out_m;

   function automatic logic [31:0] mem_word(input logic [7:0] a);
      return {a, ~a, a ^ 8'h5A, a + 8'h31};
   endfunction

   function automatic logic [63:0] ev_rd(input logic [7:0] a);
      return {4'd1, 52'd0, a};
   endfunction
   function automatic logic [63:0] ev_wr(input int i, input int j, input logic [31:0] d);
      return {4'd2, 22'd0, 2'(i), 4'(j), d};
   endfunction
   function automatic logic [63:0] ev_win(input int j, input bit last);
      return {4'd4, 55'd0, last, 4'(j)};
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endtask

   // Expected event stream for one image, built straight from the loader's contract.
   task automatic build_exp(input int rows, input int stride, input logic [7:0] base);
      logic [7:0] a;
      exp_q.delete();
      for (int r = 0; r < rows; r++) begin
         if (r >= 4) exp_q.push_back({4'd3, 60'd0});
         for (int w = 0; w < 4; w++) begin
            a = base + 8'(r * 4 + w);
            exp_q.push_back(ev_rd(a));
            exp_q.push_back(ev_wr((r > 3) ? 3 : r, w * 4, mem_word(a)));
         end
         if (r >= 3)
            for (int c = 3; c <= 15; c += stride)
               exp_q.push_back(ev_win(c, (c + stride > 15) && (r == rows - 1)));
      end
      exp_q.push_back({4'd5, 60'd0});
   endtask

   // Memory responder: one outstanding read, latency 1 or random 1..6 cycles.
   initial begin
      forever begin
         @(negedge clk);
         if (m_mem_rd && rst_n) begin
            int lat;
            logic [7:0] a;
            a = m_mem_addr;
            lat = lat_rand ? int'($urandom_range(6, 1)) : 1;
            repeat (lat) @(negedge clk);
            mem_valid = 1'b1;
            mem_data  = mem_word(a);
            @(negedge clk);
            mem_valid = 1'b0;
            mem_data  = 32'hDEAD_BEEF;
         end
      end
   end

   logic [63:0] got_ev;
   bit          have_ev;
   bit          prev_stall;
   logic [3:0]  prev_j;
   int          n_act;

   always @(negedge clk) begin
      #1;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         n_act = int'(m_buf_we) + int'(m_buf_shift) + int'(m_buf_re);
         if (n_act != 0) chk("exclusive_we_shift_re", 64'(n_act), 64'd1);
         if (prev_stall) begin
            chk("stall_win_valid", 64'(m_win_valid), 64'd1);
            chk("stall_buf_j", 64'(m_buf_j), 64'(prev_j));
         end
         prev_stall = m_win_valid && !win_ready;
         prev_j     = m_buf_j;
         have_ev = 1'b1;
         if (m_mem_rd)                     got_ev = ev_rd(m_mem_addr);
         else if (m_buf_we)                got_ev = ev_wr(int'(m_buf_i), int'(m_buf_j), m_buf_din);
         else if (m_buf_shift)             got_ev = {4'd3, 60'd0};
         else if (m_win_valid && win_ready) got_ev = ev_win(int'(m_buf_j), m_win_last);
         else if (m_done)                  got_ev = {4'd5, 60'd0};
         else                              have_ev = 1'b0;
         if (have_ev) begin
            if (exp_q.size() == 0) chk("unexpected_event", got_ev, 64'd0);
            else                   chk("event", got_ev, exp_q.pop_front());
         end
      end
   end

   task automatic pulse_start(input int s, input logic [7:0] base);
      @(negedge clk);
      img_base   = base;
      start_v[s] = 1'b1;
      @(negedge clk);
      start_v[s] = 1'b0;
      img_base   = 8'hEE;
   endtask

   task automatic run_img(input int s, input logic [7:0] base, input int stall, input bit poke);
      bit seen;
      build_exp((s == 1) ? 6 : 4, (s == 2) ? 4 : 1, base);
      sel = s;
      pulse_start(s, base);
      chk("busy_after_start", 64'(m_busy), 64'd1);
`ifdef PIC_LOADER_STALL_CNT_EN
      if (s == 0) chk("stall_cnt_cleared", 64'(if_a.stall_cnt), 64'd0);
`endif
      seen = 1'b0;
      fork
         begin
            for (int k = 0; k < 4000 && !seen; k++) begin
               @(negedge clk);
               if (m_done) begin
                  seen = 1'b1;
`ifdef PIC_LOADER_STALL_CNT_EN
                  if (s == 0) chk("stall_cnt_at_done", 64'(if_a.stall_cnt), 64'(stall));
`endif
               end
            end
         end
         begin
            if (stall > 0) begin
               for (int k = 0; k < 500 && !m_win_valid; k++) @(negedge clk);
               win_ready = 1'b0;
               repeat (stall) @(negedge clk);
               win_ready = 1'b1;
            end
            if (poke) begin
               repeat (20) @(negedge clk);
               img_base   = 8'h77;
               start_v[s] = 1'b1;
               @(negedge clk);
               start_v[s] = 1'b0;
            end
         end
      join
      chk("done_seen", 64'(seen), 64'd1);
      @(negedge clk);
      chk("idle_after_done", 64'(m_busy), 64'd0);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start_v = '0; img_base = '0; mem_valid = 1'b0; mem_data = '0;
      win_ready = 1'b1; sel = 0; lat_rand = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 64'(out_a | out_b | out_c), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_outputs", 64'(out_a | out_b | out_c), 64'd0);

      run_img(0, 8'h00, 0, 1'b0);           // 4 rows, stride 1
      run_img(1, 8'h10, 0, 1'b0);           // 6 rows, two reloads
      run_img(2, 8'h40, 5, 1'b0);           // stride 4, first window stalled 5 cycles
      lat_rand = 1'b1;
      run_img(0, 8'h00, 0, 1'b1);           // random latency, start poked while busy
      lat_rand = 1'b0;

      // Reset during the second window set, then the same image must replay cleanly.
      sel = 1;
      build_exp(6, 1, 8'h10);
      pulse_start(1, 8'h10);
      for (int k = 0; k < 500 && !m_buf_shift; k++) @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 500 && !m_win_valid; k++) @(negedge clk);
      chk("in_second_set", 64'(m_win_valid), 64'd1);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_outputs", 64'(out_a | out_b | out_c), 64'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      run_img(1, 8'h10, 0, 1'b0);

      run_img(0, 8'hF8, 7, 1'b0);           // address wrap, 7 stall cycles
      run_img(0, 8'h20, 0, 1'b0);           // stall counter must restart from 0

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
